// File: rtl/press_hold_detector.sv
// rtl/press_hold_detector.sv - multi-channel debounced short/long/held press classifier
// Optional auto-repeat while held is built only when HOLD_REPEAT_EN is defined.
module press_hold_detector #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 5000,
    parameter int REPEAT_CYCLES   = 500
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] short_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] held_o,
    output logic [N_CH-1:0] repeat_o,
    output logic            busy_o
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("press_hold_detector: invalid timing parameters");
    end

    typedef enum logic [1:0] {IDLE, PRESSED, HELD, WAIT_REL} state_t;

    logic [N_CH-1:0] sync1, sync2, db;
    logic [DB_W-1:0] db_cnt [N_CH];
    logic [HW-1:0]   hold_cnt [N_CH];
    logic [HW-1:0]   hold_n [N_CH];
    logic [HW-1:0]   hold_inc;
    state_t          state_q [N_CH];
    state_t          state_n [N_CH];
    logic [N_CH-1:0] short_q, long_q, held_q;
    logic [N_CH-1:0] short_n, long_n, held_n;
    logic            busy_q, busy_n;

`ifdef HOLD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt [N_CH];
    logic [REP_W-1:0] rep_n [N_CH];
    logic [N_CH-1:0]  repeat_q, repeat_n;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            short_q <= '0;
            long_q  <= '0;
            held_q  <= '0;
            busy_q  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                db_cnt[c]   <= '0;
                hold_cnt[c] <= '0;
                state_q[c]  <= IDLE;
`ifdef HOLD_REPEAT_EN
                rep_cnt[c]  <= '0;
`endif
            end
`ifdef HOLD_REPEAT_EN
            repeat_q <= '0;
`endif
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
            // The debounced level flips on the last of DEBOUNCE_CYCLES differing samples.
            for (int c = 0; c < N_CH; c++) begin
                if (sync2[c] == db[c]) begin
                    db_cnt[c] <= '0;
                end else if (db_cnt[c] == DB_LAST) begin
                    db_cnt[c] <= '0;
                    db[c]     <= ~db[c];
                end else begin
                    db_cnt[c] <= db_cnt[c] + 1'b1;
                end
                hold_cnt[c] <= hold_n[c];
                state_q[c]  <= state_n[c];
`ifdef HOLD_REPEAT_EN
                rep_cnt[c]  <= rep_n[c];
`endif
            end
            short_q <= short_n;
            long_q  <= long_n;
            held_q  <= held_n;
            busy_q  <= busy_n;
`ifdef HOLD_REPEAT_EN
            repeat_q <= repeat_n;
`endif
        end
    end

    always_comb begin
        short_n  = '0;
        long_n   = '0;
        held_n   = '0;
        busy_n   = 1'b0;
        hold_inc = '0;
`ifdef HOLD_REPEAT_EN
        repeat_n = '0;
`endif
        for (int c = 0; c < N_CH; c++) begin
            state_n[c] = state_q[c];
            hold_n[c]  = hold_cnt[c];
`ifdef HOLD_REPEAT_EN
            rep_n[c]   = rep_cnt[c];
`endif
            busy_n   = busy_n | (state_q[c] != IDLE);
            hold_inc = (hold_cnt[c] == HOLD_MAX) ? hold_cnt[c] : hold_cnt[c] + 1'b1;

            case (state_q[c])
                IDLE: begin
                    // Counting starts with the rise so the count equals cycles db has been high.
                    if (db[c]) begin
                        state_n[c] = PRESSED;
                        hold_n[c]  = hold_inc;
                    end
                end
                PRESSED: begin
                    if (!db[c]) begin
                        short_n[c] = 1'b1;
                        state_n[c] = IDLE;
                        hold_n[c]  = '0;
                    end else if (hold_inc == HOLD_MAX) begin
                        long_n[c]  = 1'b1;
                        held_n[c]  = 1'b1;
                        state_n[c] = HELD;
                        hold_n[c]  = hold_inc;
`ifdef HOLD_REPEAT_EN
                        rep_n[c]   = '0;
`endif
                    end else begin
                        hold_n[c] = hold_inc;
                    end
                end
                HELD: begin
                    if (!db[c]) begin
                        state_n[c] = IDLE;
                        hold_n[c]  = '0;
`ifdef HOLD_REPEAT_EN
                        rep_n[c]   = '0;
`endif
                    end else begin
                        held_n[c] = 1'b1;
                        hold_n[c] = hold_inc;
`ifdef HOLD_REPEAT_EN
                        if (rep_cnt[c] == REP_LAST) begin
                            repeat_n[c] = 1'b1;
                            rep_n[c]    = '0;
                        end else begin
                            rep_n[c] = rep_cnt[c] + 1'b1;
                        end
`endif
                    end
                end
                WAIT_REL: begin
                    if (!db[c]) state_n[c] = IDLE;
                end
                default: state_n[c] = IDLE;
            endcase

            if (!enable) begin
                state_n[c] = db[c] ? WAIT_REL : IDLE;
                hold_n[c]  = '0;
                short_n[c] = 1'b0;
                long_n[c]  = 1'b0;
                held_n[c]  = 1'b0;
`ifdef HOLD_REPEAT_EN
                rep_n[c]    = '0;
                repeat_n[c] = 1'b0;
`endif
            end
        end
    end

    assign short_o = short_q;
    assign long_o  = long_q;
    assign held_o  = held_q;
    assign busy_o  = busy_q;
`ifdef HOLD_REPEAT_EN
    assign repeat_o = repeat_q;
`else
    assign repeat_o = '0;
`endif

endmodule
